// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one external W-bit adder among NREQ
// requesters. Stage 1 registers the granted operands (driving the adder),
// stage 2 registers the sum tagged with the owning requester id.
module adder_arbiter #(
    parameter  int W    = 32,
    parameter  int NREQ = 3,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [W-1:0]        add_in1,
    output logic [W-1:0]        add_in2,
    input  logic [W-1:0]        add_sum,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [W-1:0]        rsp_sum,
    input  logic                rsp_ready
);

    logic           op_valid;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [IDW-1:0] op_id;
    logic [IDW-1:0] ptr;

    logic           adv1;
    logic           adv2;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW:0]   cand;
    logic           grant;

    assign adv2    = ~rsp_valid | rsp_ready;
    assign adv1    = ~op_valid | adv2;
    assign grant   = adv1 & gnt_found & ~rst;
    assign add_in1 = op_a;
    assign add_in2 = op_b;

    // Rotating priority search: first valid requester starting at ptr, wrapping at NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    // One-hot grant, only when stage 1 can accept.
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Stage 1: capture granted operands and advance the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_id    <= '0;
            ptr      <= '0;
        end else if (adv1) begin
            if (grant) begin
                op_valid <= 1'b1;
                op_a     <= req_a[int'(gnt_idx)*W +: W];
                op_b     <= req_b[int'(gnt_idx)*W +: W];
                op_id    <= gnt_idx;
                ptr      <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                op_valid <= 1'b0;
            end
        end
    end

    // Stage 2: register the adder result; hold it while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
        end else if (adv2) begin
            if (op_valid) begin
                rsp_valid <= 1'b1;
                rsp_sum   <= add_sum;
                rsp_id    <= op_id;
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed stimulus with a scoreboard queue; a negedge
// monitor pops expected responses on each rsp handshake.
module tb_adder_arbiter;

    localparam int W    = 32;
    localparam int NREQ = 3;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] sum;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      add_in1;
    logic [W-1:0]      add_in2;
    logic [W-1:0]      add_sum;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_ready;

    rsp_t exp_q[$];
    int   ntests = 0;
    int   nfail  = 0;

    adder_arbiter #(.W(W), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_in1   (add_in1),
        .add_in2   (add_in2),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ready (rsp_ready)
    );

    // The shared adder itself lives outside the arbiter.
    assign add_sum = add_in1 + add_in2;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    function automatic logic [1:0] id_of(input logic [2:0] g);
        case (g)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // Check the grant seen this cycle; optionally queue the response it should produce.
    task automatic step(input string name, input logic [2:0] exp_gnt,
                        input logic [31:0] exp_sum, input bit push);
        rsp_t e;
        @(negedge clk);
        chk(name, req_ready, exp_gnt);
        if (push && exp_gnt != 3'b000) begin
            e.id  = id_of(exp_gnt);
            e.sum = exp_sum;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: compare on handshake, flag unexpected responses, check hold under stall.
    logic        stall_prev = 1'b0;
    logic [1:0]  held_id;
    logic [31:0] held_sum;
    always @(negedge clk) begin
        rsp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_id", rsp_id, held_id);
                chk("hold_sum", rsp_sum, held_sum);
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    ntests++;
                    nfail++;
                    $display("FAIL unexpected_rsp: got id=%0d sum=0x%0h, expected no response",
                             rsp_id, rsp_sum);
                end else if (rsp_ready) begin
                    e = exp_q.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_sum", rsp_sum, e.sum);
                end
            end
            stall_prev = rsp_valid & ~rsp_ready;
            held_id    = rsp_id;
            held_sum   = rsp_sum;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 3'b111;
        req_a     = '0;
        req_b     = '0;
        set_op(0, 32'h100, 32'h1);
        set_op(1, 32'h200, 32'h2);
        set_op(2, 32'h300, 32'h3);

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", req_ready, 3'b000);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_add_in1", add_in1, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 3'b000;
        @(posedge clk);
        #1;

        // Single request and two-cycle latency
        set_op(0, 32'h10, 32'h4);
        req_valid = 3'b001;
        step("t2_grant", 3'b001, 32'h14, 1);
        req_valid = 3'b000;
        @(negedge clk);
        chk("t2_not_yet", rsp_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t2_latency", rsp_valid, 1);
        @(posedge clk);
        #1;
        drain("t2_drain");

        // Skip idle: ptr=1, only req0 valid
        set_op(0, 32'h7, 32'h8);
        req_valid = 3'b001;
        step("t6_skip", 3'b001, 32'hF, 1);
        set_op(0, 32'h100, 32'h1);
        req_valid = 3'b011;
        step("t6_ptr_is_1", 3'b010, 32'h202, 1);
        req_valid = 3'b100;
        step("t3_pre", 3'b100, 32'h303, 1);

        // Round-robin with all requesters held valid
        req_valid = 3'b111;
        step("t3_rr0", 3'b001, 32'h101, 1);
        step("t3_rr1", 3'b010, 32'h202, 1);
        step("t3_rr2", 3'b100, 32'h303, 1);
        step("t3_rr3", 3'b001, 32'h101, 1);
        req_valid = 3'b000;
        drain("t3_drain");

        // Wrap-around arithmetic
        set_op(1, 32'hFFFF_FFFF, 32'h0000_0002);
        req_valid = 3'b010;
        step("t5_wrap1", 3'b010, 32'h0000_0001, 1);
        set_op(2, 32'h8000_0000, 32'h8000_0000);
        req_valid = 3'b100;
        step("t5_wrap2", 3'b100, 32'h0000_0000, 1);
        req_valid = 3'b000;
        drain("t5_drain");

        // Backpressure: two grants fill the pipe, then full stall
        set_op(1, 32'h200, 32'h2);
        set_op(2, 32'h300, 32'h3);
        rsp_ready = 1'b0;
        req_valid = 3'b111;
        step("t4_g0", 3'b001, 32'h101, 1);
        step("t4_g1", 3'b010, 32'h202, 1);
        step("t4_stall0", 3'b000, 32'h0, 0);
        step("t4_stall1", 3'b000, 32'h0, 0);
        rsp_ready = 1'b1;
        step("t4_resume", 3'b100, 32'h303, 1);
        req_valid = 3'b000;
        @(negedge clk);
        chk("t4_next_valid", rsp_valid, 1);
        chk("t4_next_id", rsp_id, 1);
        @(posedge clk);
        #1;
        drain("t4_drain");

        // Reset mid-stream with an operation in stage 1
        req_valid = 3'b010;
        step("t1_pre", 3'b010, 32'h0, 0);
        rst       = 1'b1;
        req_valid = 3'b111;
        @(negedge clk);
        chk("t1_rst_ready", req_ready, 3'b000);
        chk("t1_rst_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("t1_no_stale", rsp_valid, 0);
        @(posedge clk);
        #1;
        req_valid = 3'b111;
        step("t1_ptr_zero", 3'b001, 32'h101, 1);
        req_valid = 3'b000;
        drain("t1_drain");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
